// File: rtl/mem_lsu.sv
// MEM stage: holds one EX instruction, runs one data-bus transaction for loads/stores, aligns load data.
// Latency: non-access ops valid the cycle after capture; accesses valid in DONE (gnt + rvalid min 2 cycles).
// Backpressure: stalls EX via mem_allowin while the bus is busy or mem_wb refuses; outputs hold meanwhile.
module mem_lsu #(
  parameter int XLEN          = 32,
  parameter int RF_ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pipe_flush,
  input  logic                     ex_valid,
  output logic                     mem_allowin,
  input  logic [XLEN-1:0]          ex_pc,
  input  logic [XLEN-1:0]          ex_inst,
  input  logic                     ex_req_rf,
  input  logic [RF_ADDR_WIDTH-1:0] ex_rf_waddr,
  input  logic [XLEN-1:0]          ex_alu_result,
  input  logic [XLEN-1:0]          ex_store_data,
  input  logic [3:0]               ex_ls_type,
  input  logic                     ex_exp_flag,
  output logic                     dbus_req,
  output logic                     dbus_we,
  output logic [XLEN-1:0]          dbus_addr,
  output logic [XLEN-1:0]          dbus_wdata,
  output logic [3:0]               dbus_be,
  input  logic                     dbus_gnt,
  input  logic                     dbus_rvalid,
  input  logic [XLEN-1:0]          dbus_rdata,
  input  logic                     wb_allowin,
  output logic                     mem_out_valid,
  output logic [XLEN-1:0]          mem_pc,
  output logic [XLEN-1:0]          mem_inst,
  output logic                     mem_req_rf,
  output logic [RF_ADDR_WIDTH-1:0] mem_rf_waddr,
  output logic [XLEN-1:0]          mem_wb_data,
  output logic                     mem_exp_flag,
  output logic                     mem_load_misal,
  output logic                     mem_store_misal
);

  localparam logic [3:0] LS_LB  = 4'b0001;
  localparam logic [3:0] LS_LH  = 4'b0010;
  localparam logic [3:0] LS_LW  = 4'b0011;
  localparam logic [3:0] LS_LBU = 4'b0100;
  localparam logic [3:0] LS_LHU = 4'b0101;
  localparam logic [3:0] LS_SB  = 4'b1001;
  localparam logic [3:0] LS_SH  = 4'b1010;
  localparam logic [3:0] LS_SW  = 4'b1011;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_e;

  state_e                   state_q, state_d;
  logic                     stage_valid_q;
  logic [XLEN-1:0]          pc_q, inst_q, alu_q, sdata_q, ldata_q;
  logic                     req_rf_q, exp_q, access_q, is_load_q, is_store_q;
  logic                     load_misal_q, store_misal_q;
  logic [RF_ADDR_WIDTH-1:0] waddr_q;
  logic [3:0]               ls_type_q;

  logic ex_is_load, ex_is_store, ex_misal, ex_legal;
  logic ready_go, capture;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_ext;

  // Decode the offered instruction: access kind, misalignment, whether a bus access is needed.
  always_comb begin
    ex_is_load  = 1'b0;
    ex_is_store = 1'b0;
    ex_misal    = 1'b0;
    case (ex_ls_type)
      LS_LB, LS_LBU: ex_is_load = 1'b1;
      LS_LH, LS_LHU: begin ex_is_load = 1'b1;  ex_misal = ex_alu_result[0];      end
      LS_LW:         begin ex_is_load = 1'b1;  ex_misal = |ex_alu_result[1:0];   end
      LS_SB:         ex_is_store = 1'b1;
      LS_SH:         begin ex_is_store = 1'b1; ex_misal = ex_alu_result[0];      end
      LS_SW:         begin ex_is_store = 1'b1; ex_misal = |ex_alu_result[1:0];   end
      default: ;
    endcase
    ex_legal = (ex_is_load | ex_is_store) & ~ex_misal & ~ex_exp_flag;
  end

  // Handshake: only legal accesses wait for DONE; DRAIN refuses new work until the orphan response returns.
  always_comb begin
    ready_go      = ~access_q | (state_q == S_DONE);
    mem_out_valid = stage_valid_q & ready_go;
    mem_allowin   = (state_q != S_DRAIN) & (~stage_valid_q | (ready_go & wb_allowin));
    capture       = ex_valid & mem_allowin & ~pipe_flush;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: a response is always consumed, even when a flush arrives with it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (capture && ex_legal) state_d = S_REQ;
      end
      S_REQ: begin
        if (pipe_flush)    state_d = S_IDLE;
        else if (dbus_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (pipe_flush)       state_d = dbus_rvalid ? S_IDLE : S_DRAIN;
        else if (dbus_rvalid) state_d = S_DONE;
      end
      S_DONE: begin
        if (pipe_flush)      state_d = S_IDLE;
        else if (wb_allowin) state_d = (capture && ex_legal) ? S_REQ : S_IDLE;
      end
      S_DRAIN: begin
        if (dbus_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: request only in REQ, dropped immediately on flush; lanes derived from held address.
  always_comb begin
    dbus_req   = (state_q == S_REQ) & ~pipe_flush;
    dbus_we    = is_store_q;
    dbus_addr  = {alu_q[XLEN-1:2], 2'b00};
    dbus_wdata = sdata_q;
    dbus_be    = 4'b0000;
    case (ls_type_q)
      LS_LB, LS_LBU, LS_SB: begin
        dbus_wdata = {4{sdata_q[7:0]}};
        dbus_be    = 4'b0001 << alu_q[1:0];
      end
      LS_LH, LS_LHU, LS_SH: begin
        dbus_wdata = {2{sdata_q[15:0]}};
        dbus_be    = 4'b0011 << alu_q[1:0];
      end
      LS_LW, LS_SW: dbus_be = 4'hF;
      default: ;
    endcase
  end

  // Load alignment and sign/zero extension of the returned word.
  always_comb begin
    ld_byte = dbus_rdata[{alu_q[1:0], 3'b000} +: 8];
    ld_half = dbus_rdata[{alu_q[1], 4'b0000} +: 16];
    case (ls_type_q)
      LS_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
      LS_LBU:  ld_ext = {24'h000000, ld_byte};
      LS_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
      LS_LHU:  ld_ext = {16'h0000, ld_half};
      default: ld_ext = dbus_rdata;
    endcase
  end

  // Stage occupancy: flush kills, capture fills, a WB handshake empties.
  always_ff @(posedge clk) begin
    if (!rst_n)                          stage_valid_q <= 1'b0;
    else if (pipe_flush)                 stage_valid_q <= 1'b0;
    else if (capture)                    stage_valid_q <= 1'b1;
    else if (mem_out_valid & wb_allowin) stage_valid_q <= 1'b0;
  end

  // Held instruction fields, loaded on capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= '0; inst_q <= '0; alu_q <= '0; sdata_q <= '0;
      req_rf_q <= 1'b0; waddr_q <= '0; ls_type_q <= 4'b0000; exp_q <= 1'b0;
      access_q <= 1'b0; is_load_q <= 1'b0; is_store_q <= 1'b0;
      load_misal_q <= 1'b0; store_misal_q <= 1'b0;
    end else if (capture) begin
      pc_q          <= ex_pc;
      inst_q        <= ex_inst;
      alu_q         <= ex_alu_result;
      sdata_q       <= ex_store_data;
      req_rf_q      <= ex_req_rf;
      waddr_q       <= ex_rf_waddr;
      ls_type_q     <= ex_ls_type;
      exp_q         <= ex_exp_flag;
      access_q      <= ex_legal;
      is_load_q     <= ex_is_load & ex_legal;
      is_store_q    <= ex_is_store;
      load_misal_q  <= ex_is_load & ex_misal;
      store_misal_q <= ex_is_store & ex_misal;
    end
  end

  // Latch extended load data when the response arrives for a live access.
  always_ff @(posedge clk) begin
    if (!rst_n)                                               ldata_q <= '0;
    else if ((state_q == S_WAIT) && dbus_rvalid && !pipe_flush) ldata_q <= ld_ext;
  end

  // Result presented to mem_wb.
  always_comb begin
    mem_pc          = pc_q;
    mem_inst        = inst_q;
    mem_req_rf      = req_rf_q;
    mem_rf_waddr    = waddr_q;
    mem_wb_data     = is_load_q ? ldata_q : alu_q;
    mem_load_misal  = load_misal_q;
    mem_store_misal = store_misal_q;
    mem_exp_flag    = exp_q | load_misal_q | store_misal_q;
  end

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n, pipe_flush, ex_valid, mem_allowin;
  logic [31:0] ex_pc, ex_inst, ex_alu_result, ex_store_data;
  logic        ex_req_rf, ex_exp_flag;
  logic [4:0]  ex_rf_waddr;
  logic [3:0]  ex_ls_type;
  logic        dbus_req, dbus_we, dbus_gnt, dbus_rvalid, wb_allowin;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_be;
  logic        mem_out_valid, mem_req_rf, mem_exp_flag, mem_load_misal, mem_store_misal;
  logic [31:0] mem_pc, mem_inst, mem_wb_data;
  logic [4:0]  mem_rf_waddr;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_lsu #(.XLEN(32), .RF_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush), .ex_valid(ex_valid),
    .mem_allowin(mem_allowin), .ex_pc(ex_pc), .ex_inst(ex_inst), .ex_req_rf(ex_req_rf),
    .ex_rf_waddr(ex_rf_waddr), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_ls_type(ex_ls_type), .ex_exp_flag(ex_exp_flag), .dbus_req(dbus_req), .dbus_we(dbus_we),
    .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_be(dbus_be), .dbus_gnt(dbus_gnt),
    .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata), .wb_allowin(wb_allowin),
    .mem_out_valid(mem_out_valid), .mem_pc(mem_pc), .mem_inst(mem_inst), .mem_req_rf(mem_req_rf),
    .mem_rf_waddr(mem_rf_waddr), .mem_wb_data(mem_wb_data), .mem_exp_flag(mem_exp_flag),
    .mem_load_misal(mem_load_misal), .mem_store_misal(mem_store_misal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [3:0] ls, input logic [31:0] addr, input logic [31:0] sd,
                       input logic [31:0] pc);
    ex_valid      = 1'b1;
    ex_ls_type    = ls;
    ex_alu_result = addr;
    ex_store_data = sd;
    ex_pc         = pc;
    ex_inst       = pc ^ 32'hA5A5_0000;
    ex_req_rf     = 1'b1;
    ex_rf_waddr   = pc[6:2];
    ex_exp_flag   = 1'b0;
  endtask

  // Full load: capture, grant in REQ, response next cycle, check result in DONE.
  task automatic load_txn(input string tag, input logic [3:0] ls, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [3:0] be, input logic [31:0] exp);
    @(negedge clk); offer(ls, addr, 32'h0, 32'h2000); wb_allowin = 1'b1; #1;
    chk({tag, "_allowin"}, {31'd0, mem_allowin}, 32'd1);
    @(negedge clk); ex_valid = 1'b0; dbus_gnt = 1'b1; #1;
    chk({tag, "_req"}, {31'd0, dbus_req}, 32'd1);
    chk({tag, "_addr"}, dbus_addr, {addr[31:2], 2'b00});
    chk({tag, "_be"}, {28'd0, dbus_be}, {28'd0, be});
    chk({tag, "_vld_req"}, {31'd0, mem_out_valid}, 32'd0);
    @(negedge clk); dbus_gnt = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = rdata; #1;
    chk({tag, "_vld_wait"}, {31'd0, mem_out_valid}, 32'd0);
    @(negedge clk); dbus_rvalid = 1'b0; dbus_rdata = 32'h0; #1;
    chk({tag, "_vld_done"}, {31'd0, mem_out_valid}, 32'd1);
    chk({tag, "_data"}, mem_wb_data, exp);
  endtask

  initial begin
    rst_n = 1'b0; pipe_flush = 1'b0; ex_valid = 1'b0; ex_pc = '0; ex_inst = '0;
    ex_req_rf = 1'b0; ex_rf_waddr = '0; ex_alu_result = '0; ex_store_data = '0;
    ex_ls_type = 4'b0000; ex_exp_flag = 1'b0; dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
    dbus_rdata = '0; wb_allowin = 1'b1;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_vld", {31'd0, mem_out_valid}, 32'd0);
    chk("rst_req", {31'd0, dbus_req}, 32'd0);
    chk("rst_data", mem_wb_data, 32'd0);
    chk("rst_allowin", {31'd0, mem_allowin}, 32'd1);
    rst_n = 1'b1;

    // LW 0x100: full path including held pc/inst/rd
    load_txn("lw", 4'b0011, 32'h100, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF);
    chk("lw_pc", mem_pc, 32'h2000);
    chk("lw_inst", mem_inst, 32'h2000 ^ 32'hA5A5_0000);
    chk("lw_rd", {27'd0, mem_rf_waddr}, 32'd0);
    chk("lw_req_rf", {31'd0, mem_req_rf}, 32'd1);
    chk("lw_exp", {31'd0, mem_exp_flag}, 32'd0);

    // Byte and halfword extension
    load_txn("lb", 4'b0001, 32'h103, 32'h80123456, 4'b1000, 32'hFFFFFF80);
    load_txn("lbu", 4'b0100, 32'h103, 32'h80123456, 4'b1000, 32'h00000080);
    load_txn("lh", 4'b0010, 32'h102, 32'h80017F00, 4'b1100, 32'hFFFF8001);
    load_txn("lhu", 4'b0101, 32'h102, 32'h80017F00, 4'b1100, 32'h00008001);
    load_txn("lb1", 4'b0001, 32'h101, 32'h80127F56, 4'b0010, 32'h0000007F);

    // SH 0x102 with junk upper bits in rs2
    @(negedge clk); offer(4'b1010, 32'h102, 32'hABCD1234, 32'h2100); #1;
    @(negedge clk); ex_valid = 1'b0; dbus_gnt = 1'b1; #1;
    chk("sh_req", {31'd0, dbus_req}, 32'd1);
    chk("sh_we", {31'd0, dbus_we}, 32'd1);
    chk("sh_be", {28'd0, dbus_be}, 32'h0000000C);
    chk("sh_wdata", dbus_wdata, 32'h12341234);
    @(negedge clk); dbus_gnt = 1'b0; dbus_rvalid = 1'b1; #1;
    chk("sh_vld_wait", {31'd0, mem_out_valid}, 32'd0);
    @(negedge clk); dbus_rvalid = 1'b0; #1;
    chk("sh_vld_done", {31'd0, mem_out_valid}, 32'd1);
    chk("sh_data", mem_wb_data, 32'h102);

    // SB 0x101
    @(negedge clk); offer(4'b1001, 32'h101, 32'h000000C3, 32'h2104); #1;
    @(negedge clk); ex_valid = 1'b0; dbus_gnt = 1'b1; #1;
    chk("sb_be", {28'd0, dbus_be}, 32'h00000002);
    chk("sb_wdata", dbus_wdata, 32'hC3C3C3C3);
    @(negedge clk); dbus_gnt = 1'b0; dbus_rvalid = 1'b1; #1;
    @(negedge clk); dbus_rvalid = 1'b0; #1;
    chk("sb_vld_done", {31'd0, mem_out_valid}, 32'd1);

    // Misaligned LW 0x102: no bus access, valid next cycle, flags set
    @(negedge clk); offer(4'b0011, 32'h102, 32'h0, 32'h2200); #1;
    @(negedge clk); ex_valid = 1'b0; #1;
    chk("lwmis_req", {31'd0, dbus_req}, 32'd0);
    chk("lwmis_vld", {31'd0, mem_out_valid}, 32'd1);
    chk("lwmis_lflag", {31'd0, mem_load_misal}, 32'd1);
    chk("lwmis_sflag", {31'd0, mem_store_misal}, 32'd0);
    chk("lwmis_exp", {31'd0, mem_exp_flag}, 32'd1);

    // Misaligned SH 0x101
    @(negedge clk); offer(4'b1010, 32'h101, 32'h0, 32'h2204); #1;
    @(negedge clk); ex_valid = 1'b0; #1;
    chk("shmis_req", {31'd0, dbus_req}, 32'd0);
    chk("shmis_vld", {31'd0, mem_out_valid}, 32'd1);
    chk("shmis_sflag", {31'd0, mem_store_misal}, 32'd1);
    chk("shmis_lflag", {31'd0, mem_load_misal}, 32'd0);

    // Aligned LW already carrying an exception: no access
    @(negedge clk); offer(4'b0011, 32'h104, 32'h0, 32'h2208); ex_exp_flag = 1'b1; #1;
    @(negedge clk); ex_valid = 1'b0; ex_exp_flag = 1'b0; #1;
    chk("exp_req", {31'd0, dbus_req}, 32'd0);
    chk("exp_vld", {31'd0, mem_out_valid}, 32'd1);
    chk("exp_flag", {31'd0, mem_exp_flag}, 32'd1);

    // Grant withheld 5 cycles while EX offers an ALU op
    @(negedge clk); offer(4'b0011, 32'h200, 32'h0, 32'h3000); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); offer(4'b0000, 32'h55, 32'h0, 32'h3004); #1;
      chk("stall_req", {31'd0, dbus_req}, 32'd1);
      chk("stall_addr", dbus_addr, 32'h200);
      chk("stall_allowin", {31'd0, mem_allowin}, 32'd0);
    end
    @(negedge clk); dbus_gnt = 1'b1; #1;
    chk("stall_gnt_req", {31'd0, dbus_req}, 32'd1);
    @(negedge clk); dbus_gnt = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'h11223344; #1;
    chk("stall_wait_allowin", {31'd0, mem_allowin}, 32'd0);
    @(negedge clk); dbus_rvalid = 1'b0; dbus_rdata = 32'h0; wb_allowin = 1'b0; #1;
    chk("hold_vld", {31'd0, mem_out_valid}, 32'd1);
    chk("hold_data", mem_wb_data, 32'h11223344);
    chk("hold_allowin", {31'd0, mem_allowin}, 32'd0);
    @(negedge clk); wb_allowin = 1'b1; #1;
    chk("hold2_data", mem_wb_data, 32'h11223344);
    chk("hold2_pc", mem_pc, 32'h3000);
    chk("done_allowin", {31'd0, mem_allowin}, 32'd1);
    @(negedge clk); ex_valid = 1'b0; #1;
    chk("next_alu_vld", {31'd0, mem_out_valid}, 32'd1);
    chk("next_alu_data", mem_wb_data, 32'h55);
    chk("next_alu_pc", mem_pc, 32'h3004);

    // Flush while waiting for the response: drain the orphan rvalid
    @(negedge clk); offer(4'b0011, 32'h300, 32'h0, 32'h4000); #1;
    @(negedge clk); ex_valid = 1'b0; dbus_gnt = 1'b1; #1;
    @(negedge clk); dbus_gnt = 1'b0; pipe_flush = 1'b1; #1;
    chk("fw_vld", {31'd0, mem_out_valid}, 32'd0);
    @(negedge clk); pipe_flush = 1'b0; offer(4'b0000, 32'h77, 32'h0, 32'h4010); #1;
    chk("drain_allowin", {31'd0, mem_allowin}, 32'd0);
    chk("drain_vld", {31'd0, mem_out_valid}, 32'd0);
    @(negedge clk); dbus_rvalid = 1'b1; dbus_rdata = 32'hCAFEF00D; #1;
    chk("drain_rv_allowin", {31'd0, mem_allowin}, 32'd0);
    chk("drain_rv_vld", {31'd0, mem_out_valid}, 32'd0);
    @(negedge clk); dbus_rvalid = 1'b0; dbus_rdata = 32'h0; #1;
    chk("postdrain_allowin", {31'd0, mem_allowin}, 32'd1);
    chk("postdrain_vld", {31'd0, mem_out_valid}, 32'd0);
    @(negedge clk); ex_valid = 1'b0; #1;
    chk("postdrain_alu_vld", {31'd0, mem_out_valid}, 32'd1);
    chk("postdrain_alu_data", mem_wb_data, 32'h77);

    // Flush while requesting: request drops, grant ignored
    @(negedge clk); offer(4'b0011, 32'h400, 32'h0, 32'h5000); #1;
    @(negedge clk); ex_valid = 1'b0; pipe_flush = 1'b1; dbus_gnt = 1'b1; #1;
    chk("fr_req", {31'd0, dbus_req}, 32'd0);
    @(negedge clk); pipe_flush = 1'b0; dbus_gnt = 1'b0; #1;
    chk("fr_req_after", {31'd0, dbus_req}, 32'd0);
    chk("fr_vld_after", {31'd0, mem_out_valid}, 32'd0);
    chk("fr_allowin_after", {31'd0, mem_allowin}, 32'd1);

    // Four ALU ops back to back
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); offer(4'b0000, 32'h10 + i, 32'h0, 32'h6000 + 4 * i); #1;
      if (i > 0) begin
        chk("stream_vld", {31'd0, mem_out_valid}, 32'd1);
        chk("stream_data", mem_wb_data, 32'h10 + i - 1);
        chk("stream_allowin", {31'd0, mem_allowin}, 32'd1);
      end
    end
    @(negedge clk); ex_valid = 1'b0; #1;
    chk("stream_last_vld", {31'd0, mem_out_valid}, 32'd1);
    chk("stream_last_data", mem_wb_data, 32'h13);
    @(negedge clk); #1;
    chk("stream_empty", {31'd0, mem_out_valid}, 32'd0);

    // Reset during WAIT
    @(negedge clk); offer(4'b0011, 32'h500, 32'h0, 32'h7000); #1;
    @(negedge clk); ex_valid = 1'b0; dbus_gnt = 1'b1; #1;
    @(negedge clk); dbus_gnt = 1'b0; rst_n = 1'b0; #1;
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rstw_vld", {31'd0, mem_out_valid}, 32'd0);
    chk("rstw_req", {31'd0, dbus_req}, 32'd0);
    chk("rstw_pc", mem_pc, 32'd0);
    chk("rstw_data", mem_wb_data, 32'd0);
    chk("rstw_allowin", {31'd0, mem_allowin}, 32'd1);
    chk("rstw_addr", dbus_addr, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
